// File: rtl/dma_desc_rr_arb.sv
// dma_desc_rr_arb
//   Round-robin arbiter sharing one DMA descriptor channel between PORTS
//   requesters. The granted port index is prepended to the descriptor tag.
//   Returned status is routed back to the originating port using that
//   index. Each port has a cap on descriptors in flight.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   s_axis_desc_*            per-port descriptor inputs (flattened, port 0 in LSBs)
//   s_axis_desc_ready        per-port ready, one-hot or zero (combinational)
//   m_axis_desc_*            registered granted descriptor, tag = {index, tag}
//   s_axis_desc_status_*     returned status from the DMA engine
//   m_axis_desc_status_*     per-port status, registered, 1-cycle latency
//   enable                   permits new grants
//   busy                     output pending or any descriptor in flight
//   status_error             1-cycle pulse on a status that matches nothing
//
// Optional build macro DMA_DESC_RR_ARB_STATS_EN adds:
//   stat_grant_count         per-port 32-bit wrapping grant counters
//   stat_stall_cycles        cycles with m_axis_desc_valid && !m_axis_desc_ready

// Per-port outstanding-descriptor counter.
module dma_desc_rr_arb_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,   // grant to this port
   input  logic             dec_i,   // status addressed to this port
   output logic [CNT_W-1:0] cnt_o,
   output logic             nz_d_o   // next-state count is nonzero
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_ok;

   // A status with nothing in flight is ignored, unless a grant lands in
   // the same cycle.
   assign dec_ok = dec_i && ((cnt_q != '0) || inc_i);

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_ok)      cnt_d = cnt_q + CNT_W'(1);
      else if (!inc_i && dec_ok) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign nz_d_o = |cnt_d;
endmodule

module dma_desc_rr_arb #(
   parameter int PORTS           = 4,
   parameter int PCIE_ADDR_WIDTH = 64,
   parameter int RAM_SEL_WIDTH   = 2,
   parameter int RAM_ADDR_WIDTH  = 16,
   parameter int LEN_WIDTH       = 16,
   parameter int S_TAG_WIDTH     = 8,
   parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]     s_axis_desc_pcie_addr,
   input  logic [PORTS*RAM_SEL_WIDTH-1:0]       s_axis_desc_ram_sel,
   input  logic [PORTS*RAM_ADDR_WIDTH-1:0]      s_axis_desc_ram_addr,
   input  logic [PORTS*LEN_WIDTH-1:0]           s_axis_desc_len,
   input  logic [PORTS*S_TAG_WIDTH-1:0]         s_axis_desc_tag,
   input  logic [PORTS-1:0]                     s_axis_desc_valid,
   output logic [PORTS-1:0]                     s_axis_desc_ready,
   output logic [PCIE_ADDR_WIDTH-1:0]           m_axis_desc_pcie_addr,
   output logic [RAM_SEL_WIDTH-1:0]             m_axis_desc_ram_sel,
   output logic [RAM_ADDR_WIDTH-1:0]            m_axis_desc_ram_addr,
   output logic [LEN_WIDTH-1:0]                 m_axis_desc_len,
   output logic [M_TAG_WIDTH-1:0]               m_axis_desc_tag,
   output logic                                 m_axis_desc_valid,
   input  logic                                 m_axis_desc_ready,
   input  logic [M_TAG_WIDTH-1:0]               s_axis_desc_status_tag,
   input  logic                                 s_axis_desc_status_valid,
   output logic [PORTS*S_TAG_WIDTH-1:0]         m_axis_desc_status_tag,
   output logic [PORTS-1:0]                     m_axis_desc_status_valid,
   input  logic                                 enable,
   output logic                                 busy,
   output logic                                 status_error
`ifdef DMA_DESC_RR_ARB_STATS_EN
   ,
   output logic [PORTS*32-1:0]                  stat_grant_count,
   output logic [31:0]                          stat_stall_cycles
`endif
);
   localparam int IDX_W = $clog2(PORTS);
   localparam int CNT_W = 8;

   logic [IDX_W-1:0]                  ptr_q, ptr_d;
   logic                              load, found;
   logic [IDX_W-1:0]                  gidx;
   logic [PORTS-1:0]                  elig, inc, st_hit, zero_miss, cnt_nz_d;
   logic [PORTS-1:0][CNT_W-1:0]       cnt;
   logic                              m_valid_q, m_valid_d;
   logic [PCIE_ADDR_WIDTH-1:0]        addr_q;
   logic [RAM_SEL_WIDTH-1:0]          sel_q;
   logic [RAM_ADDR_WIDTH-1:0]         raddr_q;
   logic [LEN_WIDTH-1:0]              len_q;
   logic [M_TAG_WIDTH-1:0]            tag_q;
   logic [PORTS-1:0]                  st_valid_q;
   logic [PORTS-1:0][S_TAG_WIDTH-1:0] st_tag_q;
   logic                              err_q, err_d, busy_q;
   logic [IDX_W-1:0]                  st_idx;
   logic                              st_in_range;

   // Single output register: refill when empty or being drained this cycle.
   assign load = enable && (!m_valid_q || m_axis_desc_ready);

   // First eligible port at or after the pointer, wrapping modulo PORTS.
   always_comb begin
      int j;
      found = 1'b0;
      gidx  = '0;
      for (int k = 0; k < PORTS; k++) begin
         j = (int'(ptr_q) + k) % PORTS;
         if (!found && elig[j]) begin
            found = 1'b1;
            gidx  = IDX_W'(j);
         end
      end
   end

   assign ptr_d = (gidx == IDX_W'(PORTS - 1)) ? '0 : gidx + IDX_W'(1);

   // Ready is gated by reset so every output is quiet while rst_n is low.
   assign s_axis_desc_ready = (rst_n && load && found) ? (PORTS'(1) << gidx) : '0;

   assign st_idx      = s_axis_desc_status_tag[M_TAG_WIDTH-1 -: IDX_W];
   assign st_in_range = int'(st_idx) < PORTS;

   for (genvar i = 0; i < PORTS; i++) begin : g_port
      assign elig[i]      = s_axis_desc_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
      assign inc[i]       = load && found && (gidx == IDX_W'(i));
      assign st_hit[i]    = s_axis_desc_status_valid && st_in_range && (st_idx == IDX_W'(i));
      assign zero_miss[i] = st_hit[i] && (cnt[i] == '0) && !inc[i];

      dma_desc_rr_arb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk    (clk),
         .rst_n  (rst_n),
         .inc_i  (inc[i]),
         .dec_i  (st_hit[i]),
         .cnt_o  (cnt[i]),
         .nz_d_o (cnt_nz_d[i])
      );
   end

   assign err_d     = s_axis_desc_status_valid && (!st_in_range || (|zero_miss));
   assign m_valid_d = load ? found : (m_valid_q && !m_axis_desc_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         m_valid_q  <= 1'b0;
         addr_q     <= '0;
         sel_q      <= '0;
         raddr_q    <= '0;
         len_q      <= '0;
         tag_q      <= '0;
         st_valid_q <= '0;
         st_tag_q   <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         if (load && found) begin
            ptr_q   <= ptr_d;
            addr_q  <= s_axis_desc_pcie_addr[gidx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
            sel_q   <= s_axis_desc_ram_sel[gidx*RAM_SEL_WIDTH +: RAM_SEL_WIDTH];
            raddr_q <= s_axis_desc_ram_addr[gidx*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            len_q   <= s_axis_desc_len[gidx*LEN_WIDTH +: LEN_WIDTH];
            tag_q   <= {gidx, s_axis_desc_tag[gidx*S_TAG_WIDTH +: S_TAG_WIDTH]};
         end
         // Status to a port with nothing in flight is still forwarded;
         // an out-of-range index is dropped.
         st_valid_q <= st_hit;
         for (int i = 0; i < PORTS; i++)
            if (st_hit[i]) st_tag_q[i] <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
         err_q  <= err_d;
         busy_q <= m_valid_d || (|cnt_nz_d);
      end
   end

   assign m_axis_desc_pcie_addr    = addr_q;
   assign m_axis_desc_ram_sel      = sel_q;
   assign m_axis_desc_ram_addr     = raddr_q;
   assign m_axis_desc_len          = len_q;
   assign m_axis_desc_tag          = tag_q;
   assign m_axis_desc_valid        = m_valid_q;
   assign m_axis_desc_status_valid = st_valid_q;
   assign m_axis_desc_status_tag   = st_tag_q;
   assign status_error             = err_q;
   assign busy                     = busy_q;

`ifdef DMA_DESC_RR_ARB_STATS_EN
   logic [PORTS-1:0][31:0] gcnt_q;
   logic [31:0]            stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt_q  <= '0;
         stall_q <= '0;
      end else begin
         for (int i = 0; i < PORTS; i++)
            if (inc[i]) gcnt_q[i] <= gcnt_q[i] + 32'd1;
         if (m_valid_q && !m_axis_desc_ready) stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_grant_count  = gcnt_q;
   assign stat_stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_dma_desc_rr_arb.sv
module tb_dma_desc_rr_arb;
   localparam int P    = 4;
   localparam int AW   = 64;
   localparam int SW   = 2;
   localparam int RW   = 16;
   localparam int LW   = 16;
   localparam int TW   = 8;
   localparam int MTW  = 10;
   localparam int MAXO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [P*AW-1:0]  s_addr;
   logic [P*SW-1:0]  s_sel;
   logic [P*RW-1:0]  s_raddr;
   logic [P*LW-1:0]  s_len;
   logic [P*TW-1:0]  s_tag;
   logic [P-1:0]     s_valid, s_ready;
   logic [AW-1:0]    m_addr;
   logic [SW-1:0]    m_sel;
   logic [RW-1:0]    m_raddr;
   logic [LW-1:0]    m_len;
   logic [MTW-1:0]   m_tag;
   logic             m_valid, m_ready;
   logic [MTW-1:0]   st_tag_in;
   logic             st_valid_in;
   logic [P*TW-1:0]  st_tag_out;
   logic [P-1:0]     st_valid_out;
   logic             en, busy, serr;

   dma_desc_rr_arb #(
      .PORTS(P), .PCIE_ADDR_WIDTH(AW), .RAM_SEL_WIDTH(SW), .RAM_ADDR_WIDTH(RW),
      .LEN_WIDTH(LW), .S_TAG_WIDTH(TW), .M_TAG_WIDTH(MTW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_desc_pcie_addr(s_addr), .s_axis_desc_ram_sel(s_sel),
      .s_axis_desc_ram_addr(s_raddr), .s_axis_desc_len(s_len),
      .s_axis_desc_tag(s_tag), .s_axis_desc_valid(s_valid),
      .s_axis_desc_ready(s_ready),
      .m_axis_desc_pcie_addr(m_addr), .m_axis_desc_ram_sel(m_sel),
      .m_axis_desc_ram_addr(m_raddr), .m_axis_desc_len(m_len),
      .m_axis_desc_tag(m_tag), .m_axis_desc_valid(m_valid),
      .m_axis_desc_ready(m_ready),
      .s_axis_desc_status_tag(st_tag_in), .s_axis_desc_status_valid(st_valid_in),
      .m_axis_desc_status_tag(st_tag_out), .m_axis_desc_status_valid(st_valid_out),
      .enable(en), .busy(busy), .status_error(serr)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: arbitration state as plain integers
   int             mcnt[P];
   int             mptr;
   bit             mv, mbusy, merr;
   logic [AW-1:0]  maddr;
   logic [SW-1:0]  msel;
   logic [RW-1:0]  mraddr;
   logic [LW-1:0]  mlen;
   logic [MTW-1:0] mtag;
   logic [P-1:0]   msv;
   logic [TW-1:0]  mstag;
   logic [MTW-1:0] inflight[$];   // accepted downstream, status not yet returned

   task automatic model_reset();
      for (int i = 0; i < P; i++) mcnt[i] = 0;
      mptr = 0; mv = 0; mbusy = 0; merr = 0; msv = '0; mstag = '0;
      maddr = '0; msel = '0; mraddr = '0; mlen = '0; mtag = '0;
   endtask

   task automatic drive_random(input int st_pct, input int spur_pct);
      for (int i = 0; i < P; i++) begin
         s_valid[i]            = ($urandom_range(99) < 70);
         s_addr[i*AW +: AW]    = {$urandom, $urandom};
         s_sel[i*SW +: SW]     = SW'($urandom);
         s_raddr[i*RW +: RW]   = RW'($urandom);
         s_len[i*LW +: LW]     = LW'($urandom);
         s_tag[i*TW +: TW]     = TW'($urandom);
      end
      en          = ($urandom_range(99) < 90);
      m_ready     = ($urandom_range(99) < 75);
      st_valid_in = 1'b0;
      st_tag_in   = '0;
      if (inflight.size() > 0 && $urandom_range(99) < st_pct) begin
         int k;
         k = $urandom_range(inflight.size() - 1);
         st_tag_in = inflight[k];
         inflight.delete(k);
         st_valid_in = 1'b1;
      end else if ($urandom_range(99) < spur_pct) begin
         st_tag_in   = {2'($urandom_range(P - 1)), 8'($urandom)};
         st_valid_in = 1'b1;
      end
   endtask

   // Called at posedge+1 with inputs already applied; checks ready, advances
   // one clock, then checks every registered output against the model.
   task automatic step();
      int g, idx, decidx;
      bit load;
      logic [P-1:0] exp_rdy;
      load = en && (!mv || m_ready);
      g = -1;
      if (load)
         for (int k = 0; k < P; k++) begin
            int p;
            p = (mptr + k) % P;
            if (g < 0 && s_valid[p] && mcnt[p] < MAXO) g = p;
         end
      exp_rdy = (g >= 0) ? (P'(1) << g) : '0;
      #1 chk("s_ready", s_ready, exp_rdy);
      @(posedge clk);
      if (mv && m_ready) inflight.push_back(mtag);
      msv = '0; merr = 0; decidx = -1;
      if (st_valid_in) begin
         idx = int'(st_tag_in[MTW-1:TW]);
         if (idx >= P) merr = 1;
         else begin
            msv   = P'(1) << idx;
            mstag = st_tag_in[TW-1:0];
            if (mcnt[idx] == 0 && g != idx) merr = 1;
            else decidx = idx;
         end
      end
      if (load) begin
         if (g >= 0) begin
            mv     = 1;
            maddr  = s_addr[g*AW +: AW];
            msel   = s_sel[g*SW +: SW];
            mraddr = s_raddr[g*RW +: RW];
            mlen   = s_len[g*LW +: LW];
            mtag   = {2'(g), s_tag[g*TW +: TW]};
            mptr   = (g + 1) % P;
            mcnt[g]++;
         end else mv = 0;
      end else if (m_ready) mv = 0;
      if (decidx >= 0) mcnt[decidx]--;
      mbusy = mv;
      for (int i = 0; i < P; i++) if (mcnt[i] != 0) mbusy = 1;
      #1;
      chk("m_valid", m_valid, mv);
      chk("m_tag", m_tag, mtag);
      chk("m_addr", m_addr, maddr);
      chk("m_sel", m_sel, msel);
      chk("m_raddr", m_raddr, mraddr);
      chk("m_len", m_len, mlen);
      chk("st_valid", st_valid_out, msv);
      for (int i = 0; i < P; i++)
         if (msv[i]) chk("st_tag", st_tag_out[i*TW +: TW], mstag);
      chk("st_error", serr, merr);
      chk("busy", busy, mbusy);
   endtask

   task automatic drive_all_valid();
      for (int i = 0; i < P; i++) begin
         s_valid[i]          = 1'b1;
         s_addr[i*AW +: AW]  = 64'h1000 * (i + 1);
         s_sel[i*SW +: SW]   = SW'(i);
         s_raddr[i*RW +: RW] = RW'(16'h100 + i);
         s_len[i*LW +: LW]   = LW'(64 + i);
         s_tag[i*TW +: TW]   = TW'(8'hA0 + i);
      end
      en = 1'b1; m_ready = 1'b1; st_valid_in = 1'b0; st_tag_in = '0;
   endtask

   initial begin
      s_addr = '0; s_sel = '0; s_raddr = '0; s_len = '0; s_tag = '0; s_valid = '0;
      m_ready = 1'b0; st_tag_in = '0; st_valid_in = 1'b0; en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_s_ready", s_ready, '0);
      chk("rst_st_valid", st_valid_out, '0);
      chk("rst_error", serr, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // All ports valid, ready held high: grants 0,1,2,3,0 one per cycle
      drive_all_valid();
      for (int c = 0; c < 5; c++) begin
         step();
         chk("rr_order_tag", m_tag, {2'(c % P), 8'(8'hA0 + (c % P))});
      end

      // Sparse status returns: counts reach the per-port cap
      for (int c = 0; c < 400; c++) begin drive_random(8, 2); step(); end
      // Frequent status returns, including spurious ones
      for (int c = 0; c < 400; c++) begin drive_random(50, 3); step(); end

      // Reset mid-operation: outputs clear immediately, without a clock edge
      drive_random(0, 0);
      rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 1'b0);
      chk("async_m_valid", m_valid, 1'b0);
      chk("async_st_valid", st_valid_out, '0);
      chk("async_s_ready", s_ready, '0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      drive_all_valid();
      #1 chk("first_after_rst", s_ready, 4'b0001);
      step();

      // Pre-reset descriptors now return status with no tracking behind them
      for (int c = 0; c < 300; c++) begin drive_random(30, 2); step(); end

      // Drain with grants disabled; busy must hold until the last status
      begin
         int budget;
         budget = 3000;
         while (budget > 0 && (mbusy || inflight.size() > 0)) begin
            drive_random(50, 0);
            en = 1'b0;
            s_valid = '0;
            step();
            budget--;
         end
         chk("drain_in_budget", (budget > 0), 1'b1);
         chk("drain_busy", busy, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
